// File: rtl/key_scan_ctrl.sv
// Four-key debounced scanner with press/release/long events.
// One shared debounce engine is time-multiplexed across keys by idx.
`timescale 1ns/1ps
module key_scan_ctrl #(
    parameter int unsigned SAMPLE_TIME = 4,
    parameter int unsigned LONG_TIME   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_key,
    output logic [1:0] evt_type,
    output logic       overflow
);
    localparam logic [7:0]  CNT_MAX  = 8'(SAMPLE_TIME - 1);
    localparam logic [15:0] HOLD_MAX = 16'(LONG_TIME);
    localparam logic [1:0]  EV_PRESS = 2'b01;
    localparam logic [1:0]  EV_REL   = 2'b10;
    localparam logic [1:0]  EV_LONG  = 2'b11;

    typedef struct packed {
        logic [1:0] key;
        logic [1:0] kind;
    } evt_t;

    logic [3:0]  sync1_q, sync2_q;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q [4];
    logic [7:0]  cnt_d [4];
    logic [15:0] hold_q [4];
    logic [15:0] hold_d [4];
    logic [3:0]  key_state_q, key_state_d;
    evt_t        fifo_q [4];
    evt_t        fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;

    logic        push, pop, full, accept;
    evt_t        push_evt, head;
    logic        cur_sync, cur_ks;
    logic [7:0]  cur_cnt;
    logic [15:0] cur_hold;

    always_comb begin
        idx_d       = idx_q + 2'd1;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        key_state_d = key_state_q;
        push        = 1'b0;
        push_evt    = '0;
        cur_sync    = sync2_q[idx_q];
        cur_ks      = key_state_q[idx_q];
        cur_cnt     = cnt_q[idx_q];
        cur_hold    = hold_q[idx_q];
        if (cur_sync != cur_ks && cur_cnt == CNT_MAX) begin
            key_state_d[idx_q] = cur_sync;
            cnt_d[idx_q]       = '0;
            hold_d[idx_q]      = '0;
            push               = 1'b1;
            push_evt.key       = idx_q;
            push_evt.kind      = cur_sync ? EV_PRESS : EV_REL;
        end else begin
            cnt_d[idx_q] = (cur_sync != cur_ks) ? cur_cnt + 8'd1 : 8'd0;
            if (!cur_ks) begin
                hold_d[idx_q] = '0;
            end else if (cur_hold != HOLD_MAX) begin
                hold_d[idx_q] = cur_hold + 16'd1;
                // LONG fires only on the visit that reaches the limit
                if (cur_hold + 16'd1 == HOLD_MAX) begin
                    push          = 1'b1;
                    push_evt.key  = idx_q;
                    push_evt.kind = EV_LONG;
                end
            end
        end
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop        = (count_q != 3'd0) && evt_ready;
        full       = (count_q == 3'd4);
        accept     = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        if (accept) begin
            fifo_d[wr_ptr_q] = push_evt;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, accept} - {2'b00, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            idx_q       <= '0;
            key_state_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
                fifo_q[i] <= '0;
            end
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            idx_q       <= idx_d;
            key_state_q <= key_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            fifo_q      <= fifo_d;
        end
    end

    assign head      = fifo_q[rd_ptr_q];
    assign evt_valid = (count_q != 3'd0);
    assign evt_key   = evt_valid ? head.key : 2'b00;
    assign evt_type  = evt_valid ? head.kind : 2'b00;
    assign key_state = key_state_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_key_scan_ctrl.sv
// Scoreboard bench for key_scan_ctrl: expected events queued at stimulus,
// matched against events popped from the DUT.
`timescale 1ns/1ps
module tb_key_scan_ctrl;
    localparam int ST = 4;
    localparam int LT = 8;
    localparam logic [1:0] PRESS = 2'b01;
    localparam logic [1:0] REL   = 2'b10;
    localparam logic [1:0] LONG  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'h0;
    logic       evt_ready = 1'b0;
    logic [3:0] key_state;
    logic       evt_valid;
    logic [1:0] evt_key;
    logic [1:0] evt_type;
    logic       overflow;

    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    key_scan_ctrl #(.SAMPLE_TIME(ST), .LONG_TIME(LT)) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_state(key_state), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_type(evt_type), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && evt_valid && evt_ready)
            got_q.push_back({evt_key, evt_type});

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        key_in = 4'h0;
        evt_ready = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_key(input int k, input logic v, input int max,
                            output int cyc);
        cyc = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk);
            #1;
            if (key_state[k] === v) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        key_in = 4'hF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (key_state !== 4'h0) begin
            n_bad++; $display("FAIL rst_key_state: got %h want 0", key_state);
        end
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_evt_valid: got %b want 0", evt_valid);
        end
        n_cmp++;
        if ({evt_key, evt_type} !== 4'h0) begin
            n_bad++; $display("FAIL rst_evt: got %h want 0", {evt_key, evt_type});
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL rst_overflow: got %b want 0", overflow);
        end
        apply_reset();
    endtask

    task automatic test_press();
        int cyc;
        logic [3:0] g, e;
        evt_ready = 1'b1;
        key_in[2] = 1'b1;
        exp_q.push_back({2'd2, PRESS});
        wait_key(2, 1'b1, 40, cyc);
        n_cmp++;
        if (cyc < 15 || cyc > 18) begin
            n_bad++; $display("FAIL press_latency: got %0d want 15..18", cyc);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL press_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL press_evt: got %h want %h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
        key_in[2] = 1'b0;
        exp_q.push_back({2'd2, REL});
        wait_key(2, 1'b0, 40, cyc);
        n_cmp++;
        if (cyc < 15 || cyc > 18) begin
            n_bad++; $display("FAIL release_latency: got %0d want 15..18", cyc);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL release_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL release_evt: got %h want %h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_glitch();
        evt_ready = 1'b1;
        key_in[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1 key_in[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (key_state !== 4'h0) begin
            n_bad++; $display("FAIL glitch_state: got %h want 0", key_state);
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++; $display("FAIL glitch_events: got %0d want 0", got_q.size());
        end
        got_q.delete();
    endtask

    task automatic test_long();
        int cyc;
        logic [3:0] g, e;
        evt_ready = 1'b1;
        key_in[1] = 1'b1;
        exp_q.push_back({2'd1, PRESS});
        exp_q.push_back({2'd1, LONG});
        wait_key(1, 1'b1, 40, cyc);
        n_cmp++;
        if (cyc < 0) begin
            n_bad++; $display("FAIL long_press: got timeout want key_state[1]=1");
            cyc = 0;
        end
        repeat (60 - cyc) @(posedge clk);
        #1;
        n_cmp++;
        if (key_state[1] !== 1'b1) begin
            n_bad++; $display("FAIL long_held: got %b want 1", key_state[1]);
        end
        key_in[1] = 1'b0;
        exp_q.push_back({2'd1, REL});
        wait_key(1, 1'b0, 40, cyc);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL long_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL long_evt: got %h want %h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        int cyc;
        logic [3:0] g, e;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            key_in[k] = 1'b1;
            wait_key(k, 1'b1, 40, cyc);
            key_in[k] = 1'b0;
            wait_key(k, 1'b0, 40, cyc);
            exp_q.push_back({k[1:0], PRESS});
            exp_q.push_back({k[1:0], REL});
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_early: got %b want 0", overflow);
        end
        key_in[2] = 1'b1;
        wait_key(2, 1'b1, 40, cyc);
        @(posedge clk);
        #1;
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++; $display("FAIL ovf_set: got %b want 1", overflow);
        end
        repeat (40) @(posedge clk);
        #1;
        n_cmp++;
        if ({evt_valid, evt_key, evt_type} !== 5'b10001) begin
            n_bad++; $display("FAIL ovf_head: got %b want 10001", {evt_valid, evt_key, evt_type});
        end
        evt_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL ovf_evt: got %h want %h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
        n_cmp++;
        if ({evt_valid, overflow} !== 2'b01) begin
            n_bad++; $display("FAIL ovf_sticky: got %b want 01", {evt_valid, overflow});
        end
    endtask

    task automatic test_full_push_pop();
        int cyc;
        logic [3:0] g, e;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            key_in[k] = 1'b1;
            wait_key(k, 1'b1, 40, cyc);
            key_in[k] = 1'b0;
            wait_key(k, 1'b0, 40, cyc);
            exp_q.push_back({k[1:0], PRESS});
            exp_q.push_back({k[1:0], REL});
        end
        exp_q.push_back({2'd2, PRESS});
        // key 1 was just visited; align key 2 so its 4th visit is known
        repeat (2) @(posedge clk);
        #1 key_in[2] = 1'b1;
        repeat (14) @(posedge clk);
        #1 evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        n_cmp++;
        if (key_state[2] !== 1'b1) begin
            n_bad++; $display("FAIL fpp_timing: got %b want 1", key_state[2]);
        end
        n_cmp++;
        if ({evt_valid, overflow} !== 2'b10) begin
            n_bad++; $display("FAIL fpp_ovf: got %b want 10", {evt_valid, overflow});
        end
        evt_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL fpp_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL fpp_evt: got %h want %h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [3:0] g, e;
        apply_reset();
        key_in[0] = 1'b1;
        wait_key(0, 1'b1, 40, cyc);
        key_in[0] = 1'b0;
        wait_key(0, 1'b0, 40, cyc);
        // key 0 just visited: key 3 sees the new level on visits +3, +7
        key_in[3] = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_cmp++;
        if (evt_valid !== 1'b1) begin
            n_bad++; $display("FAIL rmid_pre: got %b want 1", evt_valid);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({key_state, evt_valid, evt_key, evt_type, overflow} !== 10'h0) begin
            n_bad++; $display("FAIL rmid_outs: got %h want 0",
                              {key_state, evt_valid, evt_key, evt_type, overflow});
        end
        #1 rst = 1'b0;
        got_q.delete(); exp_q.delete();
        evt_ready = 1'b1;
        exp_q.push_back({2'd3, PRESS});
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if (key_state[3] !== 1'b0) begin
            n_bad++; $display("FAIL rmid_early: got %b want 0", key_state[3]);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (key_state[3] !== 1'b1) begin
            n_bad++; $display("FAIL rmid_full: got %b want 1", key_state[3]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL rmid_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
            if (g !== e) begin
                n_bad++; $display("FAIL rmid_evt: got %h want %h", g, e);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_long();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_TIME, default 4: number of consecutive disagreeing visits a key must show before its debounced state changes (legal range 1..255).
REQ-002 SHALL have parameter LONG_TIME, default 16: number of visits a key must remain debounced-pressed before a LONG event is raised (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port key_in, input, 4 bits: raw, asynchronous key levels; 1 = pressed.
REQ-006 SHALL have port key_state, output, 4 bits: debounced key levels.
REQ-007 SHALL have port evt_valid, output, 1 bit: head of the event FIFO is valid.
REQ-008 SHALL have port evt_ready, input, 1 bit: consumer accepts the head event.
REQ-009 SHALL have port evt_key, output, 2 bits: key index of the head event.
REQ-010 SHALL have port evt_type, output, 2 bits: head event type; 01 PRESS, 10 RELEASE, 11 LONG.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag set when an event is dropped.

Function
REQ-012 SHALL pass each key_in bit through a 2-flop synchronizer; only synchronized values are used.
REQ-013 SHALL hold a 2-bit scan index idx that increments every cycle and wraps from 3 to 0, so each key is visited once every 4 cycles; idx is the sole scheduler of the shared debounce logic.
REQ-014 SHALL on a visit to key k with sync[k]==key_state[k]: clear cnt[k] to 0.
REQ-015 SHALL on a visit to key k with sync[k]!=key_state[k] and cnt[k]<SAMPLE_TIME-1: increment cnt[k] (8 bits).
REQ-016 SHALL on a visit to key k with sync[k]!=key_state[k] and cnt[k]==SAMPLE_TIME-1: set key_state[k]<=sync[k], clear cnt[k], and push PRESS (0->1) or RELEASE (1->0) for key k.
REQ-017 SHALL on a visit to key k with key_state[k]==1 and no transition: increment hold[k] (16 bits) until it equals LONG_TIME, then saturate.
REQ-018 SHALL push exactly one LONG event for key k on the visit where hold[k] becomes equal to LONG_TIME.
REQ-019 SHALL clear hold[k] to 0 whenever key_state[k] is 0 or transitions on that visit.
REQ-020 SHALL buffer events in a 4-entry FIFO in generation order; at most one push per cycle by construction.
REQ-021 SHALL drive evt_valid=1 iff the FIFO is non-empty, with evt_key/evt_type showing the head entry and holding stable while evt_valid=1 and evt_ready=0.
REQ-022 SHALL pop the head in the cycle where evt_valid=1 and evt_ready=1.
REQ-023 SHALL when the FIFO is full and a push occurs without a pop: drop the new event, keep the existing entries unchanged, and set overflow=1.
REQ-024 SHALL when the FIFO is full and a push and a pop occur in the same cycle: accept the push, leave overflow unchanged, and keep occupancy at 4.
REQ-025 SHALL when the FIFO is empty: ignore evt_ready; a push into an empty FIFO is visible on evt_valid the next cycle (no bypass).
REQ-026 SHALL keep overflow at 1 until reset.
REQ-027 SHALL give a deterministic latency from a stable key_in change to the key_state change of 2 sync cycles + wait for the next visit (0..3 cycles) + (SAMPLE_TIME-1)*4 cycles + 1.

Reset
REQ-028 SHALL on rst=1 asynchronously clear idx, all cnt, all hold, the synchronizers, key_state=0000, FIFO pointers (evt_valid=0), evt_key=00, evt_type=00 and overflow=0.
REQ-029 SHALL when rst asserts mid-debounce or mid-hold: discard partial counts and queued events; no event is emitted on release of reset for keys already high; they debounce as new presses.

Verification (SAMPLE_TIME=4, LONG_TIME=8)
REQ-030 SHALL cover: key_in[2] 0->1 held, evt_ready=1 -> key_state[2]=1 within 2+3+13 cycles; exactly one event {key 2, PRESS}.
REQ-031 SHALL cover: key_in[0] pulses high for 8 cycles (2 visits) -> no key_state change, no event.
REQ-032 SHALL cover: key_in[1] held high for 60 cycles -> PRESS followed by exactly one LONG for key 1; release -> one RELEASE.
REQ-033 SHALL cover: evt_ready=0 with 5 events generated -> 4 queued in order, overflow=1, fifth lost; draining yields the first 4 in order.
REQ-034 SHALL cover: FIFO full with evt_ready=1 in the same cycle as a push -> no overflow, occupancy stays 4.
REQ-035 SHALL cover: rst pulsed while key 3 is mid-debounce (cnt=2) and the FIFO holds 2 events -> all outputs 0 immediately, FIFO empty, and a full SAMPLE_TIME debounce is required afterward.
